// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the reg_file_wce register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/reg_file_wce_rf_word.sv
// One storage word of the register file: async active-low reset, load enable and
// a synchronous zero that takes priority over load.
module rf_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             zero,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (zero) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_wce.sv
// Clock-enabled 1W/2R register file with a multi-cycle clear sweep (busy while sweeping).
// Optional write-through read bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_wce
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] qout_a,
    output logic [WIDTH-1:0] qout_b,
    input  logic             clr,
    output logic             busy
);

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH));
    endfunction

    rf_state_t        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             wr_acc;
    logic             sweep;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] rd_a, rd_b;

    // A write is only accepted in IDLE and loses to a simultaneous clear request.
    assign wr_acc = ce && we && (state_q == IDLE) && !clr && in_range(waddr);
    assign sweep  = ce && (state_q == CLEAR);
    assign busy   = (state_q == CLEAR);

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        rf_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (wr_acc && (waddr == AW'(i))),
            .zero  (sweep && (idx_q == AW'(i))),
            .d     (wdata),
            .q     (word_q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (in_range(raddr_a)) rd_a = word_q[raddr_a];
        if (in_range(raddr_b)) rd_b = word_q[raddr_b];
`ifdef REG_FILE_BYPASS_EN
        // Forward only accepted writes; wr_acc already excludes dropped ones.
        if (wr_acc && (raddr_a == waddr)) rd_a = wdata;
        if (wr_acc && (raddr_b == waddr)) rd_b = wdata;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_a <= '0;
            qout_b <= '0;
        end else if (ce) begin
            qout_a <= rd_a;
            qout_b <= rd_b;
        end
    end

endmodule
